// File: rtl/spmv_pkg.sv
// spmv_pkg: FSM state type and default parameters shared by the CSR SpMV engine.
package spmv_pkg;
  localparam int DW_DEF    = 32;
  localparam int AW_DEF    = 32;
  localparam int ACC_W_DEF = 64;
  localparam int RW_DEF    = 16;
  typedef enum logic [2:0] {IDLE, PTR0, PTR, NZA, NZB, EMIT, FIN} spmv_state_t;
endpackage

// File: rtl/csr_mac.sv
// csr_mac: unsigned multiply-accumulate with clear/enable; wraps, or saturates when SPMV_SAT_EN is defined.
module csr_mac #(
  parameter int DW    = 32,
  parameter int ACC_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
`ifdef SPMV_SAT_EN
  input  logic             sclr_i,
  output logic             sat_o,
`endif
  output logic [ACC_W-1:0] acc_o
);
  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] acc_q, acc_d;
`ifdef SPMV_SAT_EN
  logic [ACC_W:0]   sum;
  logic             sat_q;
  always_comb begin
    prod  = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
    sum   = {1'b0, acc_q} + (ACC_W+1)'(prod);
    acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst || sclr_i) sat_q <= 1'b0;
    else if (en_i && sum[ACC_W]) sat_q <= 1'b1;
  end
  assign sat_o = sat_q;
`else
  always_comb begin
    prod  = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
    acc_d = acc_q + ACC_W'(prod);
  end
`endif
  always_ff @(posedge clk) begin
    if (rst || clr_i) acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end
  assign acc_o = acc_q;
endmodule

// File: rtl/csr_spmv_engine.sv
// csr_spmv_engine: CSR sparse matrix x dense vector engine, one result per row over a ready/valid port.
// Optional SPMV_SAT_EN: saturating accumulator plus sticky sat output.
module csr_spmv_engine
  import spmv_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int RW    = RW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RW-1:0]    nrows,
  input  logic [AW-1:0]    row_base,
  input  logic [AW-1:0]    wdata_col_base,
  input  logic [AW-1:0]    matrix_base,
  input  logic [AW-1:0]    v_values_base,
  output logic [AW-1:0]    addr1,
  input  logic [DW-1:0]    dataIn1,
  output logic [AW-1:0]    addr2,
  input  logic [DW-1:0]    dataIn2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [RW-1:0]    res_row,
  output logic             busy,
  output logic             done,
`ifdef SPMV_SAT_EN
  output logic             sat,
`endif
  output logic             err
);
  spmv_state_t      state_q, state_d;
  logic [RW-1:0]    nrows_q, r_q;
  logic [AW-1:0]    row_base_q, col_base_q, mat_base_q, vec_base_q, addr1_q, addr2_q;
  logic [DW-1:0]    k_q, end_q, col_q, mval_q;
  logic [ACC_W-1:0] acc;
  logic             err_q, go, back, last_row, mac_clr;
  assign go       = (state_q == IDLE) && start;
  assign back     = (state_q == PTR) && (dataIn1 < k_q);
  assign last_row = (r_q + RW'(1)) >= nrows_q;
  assign mac_clr  = go || back || ((state_q == EMIT) && res_ready);
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (nrows == '0) ? FIN : PTR0;
      PTR0:    state_d = PTR;
      PTR:     state_d = (dataIn1 > k_q) ? NZA : EMIT;
      NZA:     state_d = NZB;
      NZB:     state_d = (k_q + DW'(1) < end_q) ? NZA : EMIT;
      EMIT:    if (res_ready) state_d = last_row ? FIN : PTR;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Address ports are combinational in read states and hold their last value otherwise.
  always_comb begin
    busy      = state_q != IDLE;
    done      = state_q == FIN;
    res_valid = state_q == EMIT;
    res_data  = acc;
    res_row   = r_q;
    err       = err_q;
    addr1     = (state_q == PTR0) ? row_base_q :
                (state_q == PTR)  ? row_base_q + AW'(r_q) + AW'(1) :
                (state_q == NZA)  ? col_base_q + AW'(k_q) : addr1_q;
    addr2     = (state_q == NZA)  ? mat_base_q + AW'(k_q) :
                (state_q == NZB)  ? vec_base_q + AW'(col_q) : addr2_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      nrows_q    <= '0;
      r_q        <= '0;
      row_base_q <= '0;
      col_base_q <= '0;
      mat_base_q <= '0;
      vec_base_q <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      k_q        <= '0;
      end_q      <= '0;
      col_q      <= '0;
      mval_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      addr1_q <= addr1;
      addr2_q <= addr2;
      if (go) begin
        nrows_q    <= nrows;
        row_base_q <= row_base;
        col_base_q <= wdata_col_base;
        mat_base_q <= matrix_base;
        vec_base_q <= v_values_base;
        r_q        <= '0;
        k_q        <= '0;
        end_q      <= '0;
        err_q      <= 1'b0;
      end
      if (state_q == PTR0) k_q <= dataIn1;
      if (state_q == PTR) begin
        end_q <= dataIn1;
        if (back) begin
          err_q <= 1'b1;
          k_q   <= dataIn1;
        end
      end
      if (state_q == NZA) begin
        col_q  <= dataIn1;
        mval_q <= dataIn2;
      end
      if (state_q == NZB) k_q <= k_q + DW'(1);
      if ((state_q == EMIT) && res_ready) r_q <= r_q + RW'(1);
    end
  end
  csr_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr),
    .en_i  (state_q == NZB),
    .a_i   (mval_q),
    .b_i   (dataIn2),
`ifdef SPMV_SAT_EN
    .sclr_i(go),
    .sat_o (sat),
`endif
    .acc_o (acc)
  );
endmodule

// File: tb/tb_csr_spmv_engine.sv
// tb_csr_spmv_engine: directed and randomized CSR jobs checked against a row-sum model of the matrix-vector product.
module tb_csr_spmv_engine;
  localparam int RB = 0, CB = 256, MB = 512, VB = 1024;
  logic        clk, rst, start, res_valid, res_ready, busy, done, err;
  logic [15:0] nrows, res_row;
  logic [31:0] addr1, addr2, dataIn1, dataIn2;
  logic [63:0] res_data;
  logic [31:0] mem [0:2047];
  logic        s_start, s_valid, s_busy, s_done, s_err;
  logic [7:0]  s_a1, s_a2, s_data;
  logic [3:0]  s_d1, s_d2, s_row;
  logic [3:0]  ms [0:255];
`ifdef SPMV_SAT_EN
  logic        sat, s_sat;
`endif
  int          errors = 0, checks = 0, ready_mode = 0, cyc;
  logic [63:0] exp_row [$];
  logic [63:0] exp_data [$];
  logic [63:0] got [0:15];
  logic        pv = 0, pr = 0;
  logic [31:0] pa1, pa2;
  bit          exp_err;

  assign dataIn1 = mem[addr1[10:0]];
  assign dataIn2 = mem[addr2[10:0]];
  assign s_d1    = ms[s_a1];
  assign s_d2    = ms[s_a2];

  csr_spmv_engine dut (
    .clk(clk), .rst(rst), .start(start), .nrows(nrows),
    .row_base(32'(RB)), .wdata_col_base(32'(CB)), .matrix_base(32'(MB)), .v_values_base(32'(VB)),
    .addr1(addr1), .dataIn1(dataIn1), .addr2(addr2), .dataIn2(dataIn2),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_row(res_row),
    .busy(busy), .done(done),
`ifdef SPMV_SAT_EN
    .sat(sat),
`endif
    .err(err));

  csr_spmv_engine #(.DW(4), .AW(8), .ACC_W(8), .RW(4)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .nrows(4'd1),
    .row_base(8'h00), .wdata_col_base(8'h10), .matrix_base(8'h20), .v_values_base(8'h30),
    .addr1(s_a1), .dataIn1(s_d1), .addr2(s_a2), .dataIn2(s_d2),
    .res_valid(s_valid), .res_ready(1'b1), .res_data(s_data), .res_row(s_row),
    .busy(s_busy), .done(s_done),
`ifdef SPMV_SAT_EN
    .sat(s_sat),
`endif
    .err(s_err));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: each row's result is the dot product of its nonzeros with the vector.
  function automatic bit model(input int n);
    int k, e;
    bit er = 0;
    logic [63:0] s;
    k = int'(mem[RB]);
    for (int r = 0; r < n; r++) begin
      e = int'(mem[RB + r + 1]);
      s = 0;
      if (e < k) er = 1;
      else for (int j = k; j < e; j++) s += 64'(mem[MB + j]) * 64'(mem[VB + int'(mem[CB + j])]);
      exp_row.push_back(64'(r));
      exp_data.push_back(s);
      k = e;
    end
    return er;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (pv && !pr) begin
        chk("stall_valid_held", {63'd0, res_valid}, 64'd1);
        chk("stall_addr1_held", {32'd0, addr1}, {32'd0, pa1});
        chk("stall_addr2_held", {32'd0, addr2}, {32'd0, pa2});
      end
      if (res_valid) begin
        if (exp_row.size() == 0) chk("unexpected_res_valid", 64'd1, 64'd0);
        else begin
          chk("res_row", {48'd0, res_row}, exp_row[0]);
          chk("res_data", res_data, exp_data[0]);
          if (res_ready) begin
            if (res_row < 16) got[res_row[3:0]] = res_data;
            void'(exp_row.pop_front());
            void'(exp_data.pop_front());
          end
        end
      end
    end
    pv  = res_valid && !rst;
    pr  = res_ready;
    pa1 = addr1;
    pa2 = addr2;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 1) res_ready = 1'($urandom_range(0, 1));
  end

  task automatic run_job(input int n, input bit stall, output int c);
    int stc = 0;
    logic [63:0] hd, hr, h1, h2;
    exp_err = model(n);
    for (int i = 0; i < 16; i++) got[i] = '1;
    if (ready_mode == 0) res_ready = !stall;
    @(posedge clk); #1;
    nrows = 16'(n);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    c = 0;
    while (c < 5000) begin
      @(negedge clk);
      c++;
      if (done) break;
      if (stall && res_valid && stc < 5) begin
        stc++;
        if (stc == 1) begin
          hd = res_data; hr = 64'(res_row); h1 = 64'(addr1); h2 = 64'(addr2);
        end else begin
          chk("stall_data", res_data, hd);
          chk("stall_row", 64'(res_row), hr);
          chk("stall_a1", 64'(addr1), h1);
          chk("stall_a2", 64'(addr2), h2);
        end
        if (stc == 5) begin
          @(posedge clk); #1;
          res_ready = 1;
        end
      end
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    chk("err_flag", {63'd0, err}, {63'd0, exp_err});
    chk("all_rows_emitted", 64'(exp_row.size()), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("idle_after_done", {63'd0, busy}, 64'd0);
    exp_row.delete();
    exp_data.delete();
  endtask

  task automatic load1();
    mem[RB] = 0; mem[RB+1] = 1; mem[RB+2] = 2;
    mem[CB] = 1; mem[CB+1] = 0;
    mem[MB] = 3; mem[MB+1] = 4;
    mem[VB] = 5; mem[VB+1] = 6;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
    chk({nm, "_done"}, {63'd0, done}, 64'd0);
    chk({nm, "_valid"}, {63'd0, res_valid}, 64'd0);
    chk({nm, "_err"}, {63'd0, err}, 64'd0);
    chk({nm, "_data"}, res_data, 64'd0);
    chk({nm, "_row"}, 64'(res_row), 64'd0);
    chk({nm, "_addr1"}, 64'(addr1), 64'd0);
    chk({nm, "_addr2"}, 64'(addr2), 64'd0);
  endtask

  initial begin
    int p, n;
    for (int i = 0; i < 2048; i++) mem[i] = 0;
    for (int i = 0; i < 256; i++) ms[i] = 0;
    rst = 1; start = 0; s_start = 0; nrows = 0; res_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 0;

    load1();
    run_job(2, 0, cyc);
    chk("t1_cycles", 64'(cyc), 64'd10);
    chk("t1_row0", got[0], 64'd18);
    chk("t1_row1", got[1], 64'd20);

    mem[RB] = 0; mem[RB+1] = 0; mem[RB+2] = 2;
    mem[CB] = 0; mem[CB+1] = 1;
    mem[MB] = 2; mem[MB+1] = 3;
    mem[VB] = 7; mem[VB+1] = 9;
    run_job(2, 0, cyc);
    chk("t2_cycles", 64'(cyc), 64'd10);
    chk("t2_row0", got[0], 64'd0);
    chk("t2_row1", got[1], 64'd41);

    load1();
    run_job(2, 1, cyc);
    chk("t3_row0", got[0], 64'd18);
    chk("t3_row1", got[1], 64'd20);

    mem[RB] = 0; mem[RB+1] = 3; mem[RB+2] = 1;
    mem[CB] = 0; mem[CB+1] = 1; mem[CB+2] = 0;
    mem[MB] = 1; mem[MB+1] = 2; mem[MB+2] = 3;
    mem[VB] = 10; mem[VB+1] = 100;
    run_job(2, 0, cyc);
    chk("t4_err", {63'd0, err}, 64'd1);
    chk("t4_row0", got[0], 64'd240);
    chk("t4_row1", got[1], 64'd0);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("rst_clears_err", {63'd0, err}, 64'd0);

    load1();
    @(posedge clk); #1;
    nrows = 2; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk_zero("midjob_reset");
    repeat (4) @(negedge clk);
    chk_zero("post_reset_quiet");
    run_job(0, 0, cyc);
    chk("nrows0_cycles", 64'(cyc), 64'd1);

    ms[0] = 0; ms[1] = 2;
    ms[8'h10] = 0; ms[8'h11] = 1;
    ms[8'h20] = 15; ms[8'h21] = 15;
    ms[8'h30] = 15; ms[8'h31] = 15;
    @(posedge clk); #1; s_start = 1;
    @(posedge clk); #1; s_start = 0;
    for (int i = 0; i < 50 && !s_valid; i++) @(negedge clk);
    chk("small_valid", {63'd0, s_valid}, 64'd1);
`ifdef SPMV_SAT_EN
    chk("small_sat_data", 64'(s_data), 64'd255);
    chk("small_sat_flag", {63'd0, s_sat}, 64'd1);
`else
    chk("small_wrap_data", 64'(s_data), 64'd194);
`endif
    for (int i = 0; i < 50 && !s_done; i++) @(negedge clk);
    chk("small_done", {63'd0, s_done}, 64'd1);

    ready_mode = 1;
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 8);
      p = $urandom_range(0, 3);
      mem[RB] = 32'(p);
      for (int r = 1; r <= n; r++) begin
        if ($urandom_range(0, 7) == 0 && p > 0) p = $urandom_range(0, p - 1);
        else p = p + $urandom_range(0, 4);
        mem[RB + r] = 32'(p);
      end
      for (int j = 0; j < 64; j++) begin
        mem[CB + j] = $urandom_range(0, 15);
        mem[MB + j] = $urandom;
      end
      for (int j = 0; j < 16; j++) mem[VB + j] = $urandom;
      run_job(n, 0, cyc);
    end
    ready_mode = 0;
    res_ready = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
